// File: rtl/peecc_pkg.sv
// Shared types and constants for the PEECC UART self-test harness: segment/bus-width helpers,
// top-level FSM states, the report header byte and the LFSR polynomial.
package peecc_pkg;

  localparam logic [7:0]  ReportHeader = 8'hA5;
  localparam logic [31:0] LfsrTaps     = 32'h80200003;

  // One more segment than strictly needed, so the payload always has pad room.
  function automatic int unsigned num_segs(int unsigned k, int unsigned m);
    return (k + m) / m + 1;
  endfunction

  // Segment wires followed by one invert flag per segment.
  function automatic int unsigned bus_width(int unsigned k, int unsigned m);
    return num_segs(k, m) * m + num_segs(k, m);
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StGot0,
    StRun,
    StReport
  } peecc_state_e;

endpackage

// File: rtl/peecc_if.sv
// Board-side FTDI UART pins of the PEECC self-test harness.
interface peecc_if;
  logic FTDI_BDBUS_0;  // RX into the FPGA
  logic FTDI_BDBUS_1;  // TX out of the FPGA

  modport master (output FTDI_BDBUS_0, input FTDI_BDBUS_1);
  modport slave (input FTDI_BDBUS_0, output FTDI_BDBUS_1);
endinterface

// File: rtl/peecc_codec.sv
// Combinational PEECC encoder (interleaved parity + per-segment bus-invert against the previous
// bus) and decoder (undo inversion, re-check parity).
module peecc_codec
  import peecc_pkg::*;
#(
  parameter int unsigned K = 17,
  parameter int unsigned M = 4
) (
  input  logic [K-1:0]               d_i,
  input  logic [bus_width(K, M)-1:0] prev_bus_i,
  output logic [bus_width(K, M)-1:0] bus_o,
  input  logic [bus_width(K, M)-1:0] rx_bus_i,
  output logic [K-1:0]               dec_d_o,
  output logic                       par_err_o
);
  localparam int unsigned A    = num_segs(K, M);
  localparam int unsigned PayW = A * M;

  function automatic logic [M-1:0] parity(logic [K-1:0] v);
    logic [M-1:0] p;
    p = '0;
    for (int j = 0; j < K; j++) p[j % M] ^= v[j];
    return p;
  endfunction

  function automatic int unsigned popcnt(logic [M-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < M; i++) n += 32'(v[i]);
    return n;
  endfunction

  logic [PayW-1:0] payload;

  always_comb begin
    payload          = '0;
    payload[K-1:0]   = d_i;
    payload[K +: M]  = parity(d_i);
    bus_o            = '0;
    for (int s = 0; s < A; s++) begin
      if (popcnt(payload[s*M +: M] ^ prev_bus_i[s*M +: M]) > M / 2) begin
        bus_o[s*M +: M]  = ~payload[s*M +: M];
        bus_o[PayW + s]  = 1'b1;
      end else begin
        bus_o[s*M +: M]  = payload[s*M +: M];
      end
    end
  end

  logic [K+M-1:0] dec_pay;

  always_comb begin
    dec_pay = '0;
    for (int b = 0; b < K + M; b++) dec_pay[b] = rx_bus_i[b] ^ rx_bus_i[PayW + b / M];
  end

  assign dec_d_o   = dec_pay[K-1:0];
  assign par_err_o = parity(dec_pay[K-1:0]) != dec_pay[K +: M];

  // Pad wires carry no information on the receive side.
  if (PayW > K + M) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^rx_bus_i[PayW-1:K+M];
  end

endmodule

// File: rtl/peecc_uart.sv
// 8N1 UART receiver and transmitter sharing one clock divider constant; each TX frame is followed
// by one extra idle bit-time before tx_busy_o drops.
module peecc_uart #(
  parameter int unsigned Div = 69
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic       tx_o,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  input  logic       tx_start_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_busy_o
);
  localparam int unsigned CntW    = $clog2(Div + 1);
  localparam int unsigned HalfDiv = Div / 2;

  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  logic            rx_active_q, rx_valid_q;
  logic [CntW-1:0] rx_cnt_q;
  logic [3:0]      rx_bit_q;
  logic [7:0]      rx_sh_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_active_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_sh_q     <= '0;
    end else begin
      rx_s1_q    <= rx_i;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_valid_q <= 1'b0;
      if (!rx_active_q) begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_active_q <= 1'b1;
          rx_cnt_q    <= CntW'(HalfDiv - 1);
          rx_bit_q    <= '0;
        end
      end else if (rx_cnt_q != '0) begin
        rx_cnt_q <= rx_cnt_q - 1'b1;
      end else begin
        rx_cnt_q <= CntW'(Div - 1);
        if (rx_bit_q == 4'd0) begin
          // A start bit that is high again at mid-bit was a glitch.
          if (rx_s2_q) rx_active_q <= 1'b0;
          else         rx_bit_q    <= 4'd1;
        end else if (rx_bit_q <= 4'd8) begin
          rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_q <= rx_bit_q + 4'd1;
        end else begin
          rx_active_q <= 1'b0;
          rx_valid_q  <= rx_s2_q;  // framing error drops the byte
        end
      end
    end
  end

  assign rx_valid_o = rx_valid_q;
  assign rx_data_o  = rx_sh_q;

  logic            tx_q, tx_active_q;
  logic [CntW-1:0] tx_cnt_q;
  logic [3:0]      tx_bit_q;
  logic [7:0]      tx_sh_q;

  // Bit slots: 0 start, 1..8 data, 9 stop, 10 inter-byte idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_q        <= 1'b1;
      tx_active_q <= 1'b0;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_sh_q     <= '0;
    end else if (!tx_active_q) begin
      if (tx_start_i) begin
        tx_active_q <= 1'b1;
        tx_q        <= 1'b0;
        tx_cnt_q    <= CntW'(Div - 1);
        tx_bit_q    <= '0;
        tx_sh_q     <= tx_data_i;
      end
    end else if (tx_cnt_q != '0) begin
      tx_cnt_q <= tx_cnt_q - 1'b1;
    end else begin
      tx_cnt_q <= CntW'(Div - 1);
      if (tx_bit_q == 4'd10) begin
        tx_active_q <= 1'b0;
      end else begin
        tx_bit_q <= tx_bit_q + 4'd1;
        if (tx_bit_q < 4'd8) begin
          tx_q    <= tx_sh_q[0];
          tx_sh_q <= {1'b0, tx_sh_q[7:1]};
        end else begin
          tx_q <= 1'b1;
        end
      end
    end
  end

  assign tx_o      = tx_q;
  assign tx_busy_o = tx_active_q;

endmodule

// File: rtl/peecc_uart_top.sv
// PEECC self-test top: UART command in, LFSR words through encoder/fault/decoder, counters out.
// Optional M_HEADER debug pin enabled by defining PEECC_HEADER_DEBUG_EN.
module peecc_uart_top
  import peecc_pkg::*;
#(
  parameter int unsigned K     = 17,
  parameter int unsigned M     = 4,
  parameter int unsigned ClkHz = 4000000,
  parameter int unsigned Baud  = 57600
) (
  input  logic M_CLK_OSC,
  input  logic M_RESET_B,
`ifdef PEECC_HEADER_DEBUG_EN
  output logic M_HEADER,
`endif
  peecc_if.slave ftdi
);
  localparam int unsigned W   = bus_width(K, M);
  localparam int unsigned Div = ClkHz / Baud;

  logic       rx_valid, tx_start, tx_busy;
  logic [7:0] rx_data, tx_data;

  peecc_uart #(
    .Div (Div)
  ) u_uart (
    .clk_i      (M_CLK_OSC),
    .rst_i      (M_RESET_B),
    .rx_i       (ftdi.FTDI_BDBUS_0),
    .tx_o       (ftdi.FTDI_BDBUS_1),
    .rx_valid_o (rx_valid),
    .rx_data_o  (rx_data),
    .tx_start_i (tx_start),
    .tx_data_i  (tx_data),
    .tx_busy_o  (tx_busy)
  );

  peecc_state_e state_q, state_d;
  logic [7:0]   cmd_q, fault_q;
  logic [16:0]  words_q;
  logic [31:0]  lfsr_q;
  logic [W-1:0] prev_bus_q, bus_tx, bus_rx, fault_mask;
  logic [15:0]  mis_q, det_q;
  logic [2:0]   rpt_idx_q;
  logic         tx_pend_q;
  logic [K-1:0] dec_d;
  logic         par_err, dec_match;

  peecc_codec #(
    .K (K),
    .M (M)
  ) u_codec (
    .d_i        (lfsr_q[K-1:0]),
    .prev_bus_i (prev_bus_q),
    .bus_o      (bus_tx),
    .rx_bus_i   (bus_rx),
    .dec_d_o    (dec_d),
    .par_err_o  (par_err)
  );

  // Fault selector F names wire F-1; zero or out-of-range means a clean bus.
  always_comb begin
    fault_mask = '0;
    if (fault_q != 8'd0 && 32'(fault_q) <= W) fault_mask[fault_q - 8'd1] = 1'b1;
  end

  assign bus_rx    = bus_tx ^ fault_mask;
  assign dec_match = dec_d == lfsr_q[K-1:0];

  always_comb begin
    state_d  = state_q;
    tx_start = 1'b0;
    unique case (state_q)
      StIdle:   if (rx_valid) state_d = StGot0;
      StGot0:   if (rx_valid) state_d = StRun;
      StRun:    if (words_q == 17'd1) state_d = StReport;
      StReport: begin
        if (!tx_busy && !tx_pend_q) begin
          if (rpt_idx_q == 3'd5) state_d = StIdle;
          else                   tx_start = 1'b1;
        end
      end
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    case (rpt_idx_q)
      3'd1:    tx_data = mis_q[15:8];
      3'd2:    tx_data = mis_q[7:0];
      3'd3:    tx_data = det_q[15:8];
      3'd4:    tx_data = det_q[7:0];
      default: tx_data = ReportHeader;
    endcase
  end

  always_ff @(posedge M_CLK_OSC or posedge M_RESET_B) begin
    if (M_RESET_B) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge M_CLK_OSC or posedge M_RESET_B) begin
    if (M_RESET_B) begin
      cmd_q      <= '0;
      fault_q    <= '0;
      words_q    <= '0;
      lfsr_q     <= '0;
      prev_bus_q <= '0;
      mis_q      <= '0;
      det_q      <= '0;
      rpt_idx_q  <= '0;
      tx_pend_q  <= 1'b0;
    end else begin
      // Holds off a second start until tx_busy reflects the one just issued.
      tx_pend_q <= tx_start;
      unique case (state_q)
        StIdle: if (rx_valid) cmd_q <= rx_data;
        StGot0: begin
          if (rx_valid) begin
            fault_q    <= rx_data;
            words_q    <= ({9'd0, cmd_q} + 17'd1) << 8;
            lfsr_q     <= 32'h1;
            prev_bus_q <= '0;
            mis_q      <= '0;
            det_q      <= '0;
            rpt_idx_q  <= '0;
          end
        end
        StRun: begin
          lfsr_q     <= (lfsr_q >> 1) ^ (lfsr_q[0] ? LfsrTaps : 32'h0);
          prev_bus_q <= bus_rx;
          words_q    <= words_q - 17'd1;
          if (!dec_match && mis_q != 16'hFFFF) mis_q <= mis_q + 16'd1;
          if (par_err && det_q != 16'hFFFF)    det_q <= det_q + 16'd1;
        end
        StReport: if (tx_start) rpt_idx_q <= rpt_idx_q + 3'd1;
        default: ;
      endcase
    end
  end

`ifdef PEECC_HEADER_DEBUG_EN
  logic hdr_q;

  always_ff @(posedge M_CLK_OSC or posedge M_RESET_B) begin
    if (M_RESET_B) begin
      hdr_q <= 1'b1;
    end else if (state_q == StIdle) begin
      hdr_q <= 1'b1;
    end else if (state_q == StRun) begin
      hdr_q <= dec_match;
    end
  end

  assign M_HEADER = hdr_q;
`endif

endmodule

// File: tb/tb_peecc_uart_top.sv
// Directed bench for peecc_uart_top: UART commands in, 5-byte reports checked against
// hand-computed counts at the default geometry (k=17, M=4, W=30, DIV=69).
module tb_peecc_uart_top;
  localparam int Div = 4000000 / 57600;
  localparam int RxTimeout = 4000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  peecc_if ftdi ();

`ifdef PEECC_HEADER_DEBUG_EN
  logic m_header;
`endif

  peecc_uart_top dut (
    .M_CLK_OSC (clk),
    .M_RESET_B (rst),
`ifdef PEECC_HEADER_DEBUG_EN
    .M_HEADER  (m_header),
`endif
    .ftdi      (ftdi.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop);
    ftdi.FTDI_BDBUS_0 = 1'b0;
    repeat (Div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ftdi.FTDI_BDBUS_0 = b[i];
      repeat (Div) @(negedge clk);
    end
    ftdi.FTDI_BDBUS_0 = stop;
    repeat (Div) @(negedge clk);
    ftdi.FTDI_BDBUS_0 = 1'b1;
    repeat (Div) @(negedge clk);
  endtask

  task automatic wait_tx_start(output bit ok);
    int waited = 0;
    while (ftdi.FTDI_BDBUS_1 !== 1'b0 && waited < RxTimeout) begin
      @(negedge clk);
      waited++;
    end
    ok = (ftdi.FTDI_BDBUS_1 === 1'b0);
    if (!ok) check("tx_start_timeout", {31'd0, ftdi.FTDI_BDBUS_1}, 32'd0);
  endtask

  task automatic uart_recv(input string tag, output logic [7:0] b);
    bit ok;
    b = 8'h00;
    wait_tx_start(ok);
    if (!ok) return;
    repeat (Div / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (Div) @(negedge clk);
      b[i] = ftdi.FTDI_BDBUS_1;
    end
    repeat (Div) @(negedge clk);
    check({tag, "_stop"}, {31'd0, ftdi.FTDI_BDBUS_1}, 32'd1);
  endtask

  task automatic run_cmd(input string tag, input logic [7:0] c, input logic [7:0] f,
                         input logic [15:0] exp_mis, input logic [15:0] exp_det);
    logic [7:0] exp_b [5];
    logic [7:0] got;
    exp_b[0] = 8'hA5;
    exp_b[1] = exp_mis[15:8];
    exp_b[2] = exp_mis[7:0];
    exp_b[3] = exp_det[15:8];
    exp_b[4] = exp_det[7:0];
    uart_send(c, 1'b1);
    uart_send(f, 1'b1);
    for (int i = 0; i < 5; i++) begin
      uart_recv($sformatf("%s_b%0d", tag, i), got);
      check($sformatf("%s_b%0d", tag, i), {24'd0, got}, {24'd0, exp_b[i]});
    end
    repeat (3 * Div) @(negedge clk);
  endtask

  initial begin
    int lows;
    bit ok;
    ftdi.FTDI_BDBUS_0 = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_tx", {31'd0, ftdi.FTDI_BDBUS_1}, 32'd1);
    rst = 1'b0;

    lows = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (ftdi.FTDI_BDBUS_1 !== 1'b1) lows++;
    end
    check("idle_tx_low_cycles", lows, 0);
`ifdef PEECC_HEADER_DEBUG_EN
    check("idle_header", {31'd0, m_header}, 32'd1);
`endif

    run_cmd("clean", 8'h00, 8'h00, 16'h0000, 16'h0000);
    run_cmd("flip_d0", 8'h00, 8'h01, 16'h0100, 16'h0100);
    run_cmd("flip_pad", 8'h00, 8'h16, 16'h0000, 16'h0000);
    run_cmd("flip_flag0", 8'h00, 8'h19, 16'h0100, 16'h0100);

    // Bad stop bit: byte must be discarded, leaving the command parser at byte 0.
    uart_send(8'h3C, 1'b0);
    repeat (2 * Div) @(negedge clk);
    run_cmd("after_frame_err", 8'h00, 8'h00, 16'h0000, 16'h0000);

    // Reset during the header's start bit must force TX high immediately.
    uart_send(8'h00, 1'b1);
    uart_send(8'h00, 1'b1);
    wait_tx_start(ok);
    repeat (30) @(negedge clk);
    check("mid_report_tx_low", {31'd0, ftdi.FTDI_BDBUS_1}, 32'd0);
    rst = 1'b1;
    #1;
    check("mid_report_reset_tx", {31'd0, ftdi.FTDI_BDBUS_1}, 32'd1);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (ftdi.FTDI_BDBUS_1 !== 1'b1) lows++;
    end
    check("post_reset_tx_low_cycles", lows, 0);
    run_cmd("after_reset", 8'h00, 8'h01, 16'h0100, 16'h0100);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
